// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller with memory-wait FSM and timeout trap.
// Optional perf counters: define PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_exe,
  output logic             freeze_mem,
  output logic             flush_id,
  output logic             flush_exe,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2,
    BAD      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  state_e           st_q, st_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             frz_front, frz_back;
  logic             flush, stall_ev;
  logic             mem_stall;

  assign mem_stall = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= RUN;
      tmo_q   <= '0;
      mem_err <= 1'b0;
    end else begin
      st_q  <= st_d;
      tmo_q <= tmo_d;
      if (st_d == ERR)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    st_d      = st_q;
    tmo_d     = tmo_q;
    frz_front = 1'b0;
    frz_back  = 1'b0;
    flush     = 1'b0;
    stall_ev  = 1'b0;
    unique case (st_q)
      MEM_WAIT: begin
        frz_front = ~mem_ready;
        frz_back  = ~mem_ready;
        if (mem_ready) begin
          st_d  = RUN;
          tmo_d = '0;
        end else if (tmo_q == TMO) begin
          st_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ERR: begin
        frz_front = 1'b1;
        frz_back  = 1'b1;
      end
      RUN, BAD: begin
        st_d  = RUN;
        tmo_d = '0;
        // Memory wait outranks branch, branch outranks hazard.
        if (mem_stall) begin
          frz_front = 1'b1;
          frz_back  = 1'b1;
          if (st_q == RUN) begin
            st_d  = MEM_WAIT;
            tmo_d = CNT_W'(1);
          end
        end else if (branch_taken) begin
          flush = 1'b1;
        end else if (hazard) begin
          frz_front = 1'b1;
          stall_ev  = 1'b1;
        end
      end
    endcase
  end

  assign freeze_if  = frz_front;
  assign freeze_id  = frz_front;
  assign freeze_exe = frz_back;
  assign freeze_mem = frz_back;
  assign flush_id   = flush;
  assign flush_exe  = flush;
  assign state      = st_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, stall_ev);
      wait_cnt  <= sat_inc(wait_cnt, st_q == MEM_WAIT);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{clr_cnt, stall_ev};
  assign stall_cnt   = '0;
  assign wait_cnt    = '0;
  assign flush_cnt   = '0;
`endif

endmodule
